// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : Requests BCD conversions of the displayed value and scans the
//               digits of a multiplexed 7-segment display. Leading-zero
//               blanking is enabled by defining DISPLAY_LZB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 10000,
    parameter int WAIT_MAX = 64,
    localparam int SEL_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           value,
    input  logic                  refresh,
    output logic                  conv_start,
    input  logic [4*DIGITS-1:0]   conv_bcd,
    input  logic                  conv_dv,
    output logic                  busy,
    output logic                  conv_timeout,
    output logic [SEL_W-1:0]      digit_sel,
    output logic [3:0]            digit,
    output logic                  digit_blank,
    output logic [DIGITS-1:0]     control
);

    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int WAIT_W  = $clog2(WAIT_MAX);

    localparam logic [PRESC_W-1:0] c_presc_last = PRESC_W'(SCAN_DIV - 1);
    localparam logic [WAIT_W-1:0]  c_wait_last  = WAIT_W'(WAIT_MAX - 1);
    localparam logic [SEL_W-1:0]   c_sel_last   = SEL_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0]  c_one_hot0   = DIGITS'(1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_wait  = 2'd2;
    localparam logic [1:0] c_latch = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [31:0]           r_last_value;
    logic                  r_pend;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic [PRESC_W-1:0]    r_presc;
    logic [SEL_W-1:0]      r_sel;
    logic [SEL_W-1:0]      w_sel_nxt;
    logic                  w_tick;
    logic                  w_wait_last;
    logic [DIGITS-1:0]     w_blank_mask;
    logic [3:0]            r_digit;
    logic                  r_blank;
    logic [DIGITS-1:0]     r_control;

    assign w_wait_last = (r_wait_cnt == c_wait_last);

    // ------------------------------------------------------------------
    // Conversion sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (r_pend) w_state_nxt = c_start;
            c_start: w_state_nxt = c_wait;
            c_wait: begin
                if (conv_dv)          w_state_nxt = c_latch;
                else if (w_wait_last) w_state_nxt = c_start;
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        conv_start   = (r_state == c_start);
        busy         = (r_state != c_idle);
        conv_timeout = (r_state == c_wait) && !conv_dv && w_wait_last;
    end

    // The value difference is ignored in START: that edge is the one that
    // captures value into last_value, so it must not re-arm the request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend       <= 1'b1;
            r_last_value <= '0;
            r_wait_cnt   <= '0;
            r_bcd        <= '0;
        end else begin
            if (r_state == c_idle && r_pend) begin
                r_pend <= 1'b0;
            end else if (refresh || (value != r_last_value && r_state != c_start)) begin
                r_pend <= 1'b1;
            end

            if (r_state == c_start) begin
                r_last_value <= value;
                r_wait_cnt   <= '0;
            end else if (r_state == c_wait && !conv_dv && !w_wait_last) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (r_state == c_wait && conv_dv) begin
                r_bcd <= conv_bcd;
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit scan
    // ------------------------------------------------------------------
`ifdef DISPLAY_LZB_EN
    // A digit is blank when it and every more significant digit are zero.
    for (genvar i = 0; i < DIGITS; i++) begin : g_blank
        if (i == 0) begin : g_lsd
            assign w_blank_mask[i] = 1'b0;
        end else begin : g_upper
            assign w_blank_mask[i] = ~|r_bcd[4*DIGITS-1:4*i];
        end
    end
`else
    assign w_blank_mask = '0;
`endif

    assign w_tick    = (r_presc == c_presc_last);
    assign w_sel_nxt = w_tick ? ((r_sel == c_sel_last) ? '0 : r_sel + 1'b1) : r_sel;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_presc   <= '0;
            r_sel     <= '0;
            r_digit   <= '0;
            r_blank   <= 1'b0;
            r_control <= ~c_one_hot0;
        end else begin
            r_presc   <= w_tick ? '0 : r_presc + 1'b1;
            r_sel     <= w_sel_nxt;
            r_digit   <= r_bcd[4*w_sel_nxt +: 4];
            r_blank   <= w_blank_mask[w_sel_nxt];
            r_control <= ~(c_one_hot0 << w_sel_nxt);
        end
    end

    assign digit_sel   = r_sel;
    assign digit       = r_digit;
    assign digit_blank = r_blank;
    assign control     = r_control;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_ctrl
// Description : Directed, scoreboard-based bench for display_scan_ctrl with a
//               behavioural BCD converter of programmable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

    localparam int DIGITS   = 8;
    localparam int SCAN_DIV = 4;
    localparam int WAIT_MAX = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] value;
    logic        refresh;
    logic        conv_start;
    logic [31:0] conv_bcd;
    logic        conv_dv;
    logic        busy;
    logic        conv_timeout;
    logic [2:0]  digit_sel;
    logic [3:0]  digit;
    logic        digit_blank;
    logic [7:0]  control;

    int vectors     = 0;
    int miscompares = 0;
    int lat         = 7;
    logic [31:0] exp_q[$];

    display_scan_ctrl #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .value        (value),
        .refresh      (refresh),
        .conv_start   (conv_start),
        .conv_bcd     (conv_bcd),
        .conv_dv      (conv_dv),
        .busy         (busy),
        .conv_timeout (conv_timeout),
        .digit_sel    (digit_sel),
        .digit        (digit),
        .digit_blank  (digit_blank),
        .control      (control)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] blank_of(input logic [31:0] b);
        logic [7:0] m;
        m = '0;
`ifdef DISPLAY_LZB_EN
        for (int i = 1; i < 8; i++) m[i] = ((b >> (4*i)) == 32'd0);
`endif
        return m;
    endfunction

    // Converter model: start seen in a cycle, done pulse 'lat' cycles later.
    initial begin
        logic        st;
        logic        rs;
        logic [31:0] v;
        logic [31:0] cap;
        int          cnt;
        conv_dv  = 1'b0;
        conv_bcd = '0;
        cap      = '0;
        cnt      = 0;
        forever begin
            @(negedge clock);
            st = conv_start;
            rs = reset;
            v  = value;
            @(posedge clock);
            #1;
            conv_dv = 1'b0;
            if (rs) begin
                cnt = 0;
            end else if (st) begin
                cap = to_bcd(int'(v));
                cnt = lat;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    conv_dv  = 1'b1;
                    conv_bcd = cap;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_quiet(output int starts, output int touts);
        int idle_run;
        int n;
        idle_run = 0;
        n        = 0;
        starts   = 0;
        touts    = 0;
        while (idle_run < 4 && n < 400) begin
            @(negedge clock);
            n++;
            if (conv_start === 1'b1)   starts++;
            if (conv_timeout === 1'b1) touts++;
            if (busy === 1'b0) idle_run++;
            else               idle_run = 0;
        end
        check("settle", 32'(idle_run >= 4), 32'd1);
    endtask

    // Pops the expected BCD and checks one full refresh period slot by slot.
    task automatic scan_check(input string tag);
        logic [31:0] e;
        logic [7:0]  m;
        logic [7:0]  ctl;
        int          n;
        int          s;
        check({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        m = blank_of(e);
        n = 0;
        while (digit_sel !== 3'd7 && n < 100) begin @(negedge clock); n++; end
        while (digit_sel !== 3'd0 && n < 200) begin @(negedge clock); n++; end
        check({tag, "_sync"}, 32'(n < 200), 32'd1);
        for (int i = 0; i < DIGITS*SCAN_DIV; i++) begin
            if (i > 0) @(negedge clock);
            s   = i / SCAN_DIV;
            ctl = ~(8'd1 << s);
            check({tag, "_sel"},     32'(digit_sel),   32'(s));
            check({tag, "_control"}, 32'(control),     32'(ctl));
            check({tag, "_digit"},   32'(digit),       32'(e[4*s +: 4]));
            check({tag, "_blank"},   32'(digit_blank), 32'(m[s]));
        end
        @(negedge clock);
        check({tag, "_wrap"}, 32'(digit_sel), 32'd0);
    endtask

    initial begin
        int st;
        int to;
        int n;
        int last_start;
        int prev_to;

        // Reset state, then power-on conversion; latency 7 is the last one accepted.
        reset   = 1'b1;
        refresh = 1'b0;
        value   = 32'd1234;
        lat     = 7;
        exp_q.push_back(to_bcd(1234));
        @(negedge clock);
        check("rst_conv_start", 32'(conv_start),   32'd0);
        check("rst_busy",       32'(busy),         32'd0);
        check("rst_timeout",    32'(conv_timeout), 32'd0);
        check("rst_digit",      32'(digit),        32'd0);
        check("rst_blank",      32'(digit_blank),  32'd0);
        check("rst_control",    32'(control),      32'hFE);
        check("rst_sel",        32'(digit_sel),    32'd0);
        @(posedge clock); #1 reset = 1'b0;
        run_quiet(st, to);
        check("pwr_starts",   32'(st), 32'd1);
        check("pwr_timeouts", 32'(to), 32'd0);
        scan_check("pwr");

        // Value change latency: conv_start exactly two edges after the change.
        @(posedge clock); #1 value = 32'd99;
        exp_q.push_back(to_bcd(99));
        @(negedge clock); check("chg_cs0", 32'(conv_start), 32'd0);
        @(negedge clock); check("chg_cs1", 32'(conv_start), 32'd0);
        @(negedge clock); check("chg_cs2", 32'(conv_start), 32'd1);
        check("chg_busy", 32'(busy), 32'd1);
        @(negedge clock); check("chg_cs3", 32'(conv_start), 32'd0);
        run_quiet(st, to);
        check("chg_extra_starts", 32'(st), 32'd0);
        scan_check("v99");

        // Refresh with unchanged value.
        @(posedge clock); #1 refresh = 1'b1;
        exp_q.push_back(to_bcd(99));
        @(posedge clock); #1 refresh = 1'b0;
        run_quiet(st, to);
        check("refresh_starts", 32'(st), 32'd1);
        scan_check("refresh");

        // Refresh coincident with a value change.
        @(posedge clock); #1 begin value = 32'd100; refresh = 1'b1; end
        exp_q.push_back(to_bcd(100));
        @(posedge clock); #1 refresh = 1'b0;
        run_quiet(st, to);
        check("refchg_starts", 32'(st), 32'd1);
        scan_check("v100");

        // Zero: only digit 0 is unblanked under blanking.
        @(posedge clock); #1 value = 32'd0;
        exp_q.push_back(to_bcd(0));
        run_quiet(st, to);
        check("zero_starts", 32'(st), 32'd1);
        scan_check("zero");

        // 5 -> 6 -> 7 while WAIT is active: one further conversion, of 7.
        lat = 6;
        @(posedge clock); #1 value = 32'd5;
        n = 0;
        while (conv_start !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        check("burst_first_start", 32'(conv_start), 32'd1);
        @(negedge clock);
        @(negedge clock);
        @(posedge clock); #1 value = 32'd6;
        @(posedge clock); #1 value = 32'd7;
        exp_q.push_back(to_bcd(7));
        run_quiet(st, to);
        check("burst_further_starts", 32'(st), 32'd1);
        scan_check("burst");

        // Latency 8 lands in START and is ignored: endless retries.
        lat = 8;
        @(posedge clock); #1 value = 32'd42;
        exp_q.push_back(to_bcd(42));
        last_start = -1;
        prev_to    = -1;
        to         = 0;
        n          = 0;
        while (to < 4 && n < 80) begin
            @(negedge clock);
            n++;
            if (conv_start === 1'b1) last_start = n;
            if (last_start >= 0) check("to_busy_held", 32'(busy), 32'd1);
            if (conv_timeout === 1'b1) begin
                check("to_after_start", 32'(n - last_start), 32'(WAIT_MAX));
                if (prev_to >= 0) check("to_period", 32'(n - prev_to), 32'(WAIT_MAX + 1));
                prev_to = n;
                to++;
            end
        end
        check("to_count", 32'(to), 32'd4);
        lat = 3;
        run_quiet(st, to);
        scan_check("retry");

        // Reset in the middle of a conversion.
        lat = 6;
        @(posedge clock); #1 value = 32'd555;
        exp_q.push_back(to_bcd(555));
        n = 0;
        while (conv_start !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        @(negedge clock);
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        check("mid_rst_busy",    32'(busy),      32'd0);
        check("mid_rst_digit",   32'(digit),     32'd0);
        check("mid_rst_control", 32'(control),   32'hFE);
        check("mid_rst_sel",     32'(digit_sel), 32'd0);
        @(posedge clock); #1 reset = 1'b0;
        run_quiet(st, to);
        check("mid_rst_starts", 32'(st), 32'd1);
        scan_check("v555");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
